// File: rtl/pl_alu_pkg.sv
// pl_alu_pkg: ALUCtrl encoding, execute-stage states and shared helpers.
package pl_alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_e;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} exec_state_e;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int SHAMT_W = $clog2(DEF_DATA_WIDTH);
  function automatic logic is_shift(logic [3:0] c);
    return c == ALU_SLL || c == ALU_SRL || c == ALU_SRA;
  endfunction
endpackage

// File: rtl/pl_shift_step.sv
// pl_shift_step: one bounded shift iteration (k <= STEP) in SLL/SRL/SRA mode.
module pl_shift_step
  import pl_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STEP = 4,
  localparam int KW = $clog2(STEP + 1)
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [KW-1:0]         k_i,
  input  alu_ctrl_e             mode_i,
  output logic [DATA_WIDTH-1:0] data_o
);
  logic [DATA_WIDTH-1:0] sra;
  // Kept apart so the arithmetic shift is not coerced unsigned by the ternary.
  assign sra = $signed(data_i) >>> k_i;
  always_comb data_o = mode_i == ALU_SLL ? data_i << k_i : mode_i == ALU_SRA ? sra : data_i >> k_i;
endmodule

// File: rtl/pl_alu_exec.sv
// pl_alu_exec: execute-stage ALU with valid/ready handshake and iterative shifter.
module pl_alu_exec
  import pl_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STEP = 4,
  parameter int TAG_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  busy
);
  localparam int SW = $clog2(DATA_WIDTH);
  localparam int KW = $clog2(STEP + 1);
  exec_state_e state_q, state_d;
  alu_ctrl_e op_q, op_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, result_q, result_d, shifted, alu_res;
  logic [SW-1:0] rem_q, rem_d, shamt;
  logic [KW-1:0] k;
  logic [TAG_WIDTH-1:0] tag_q, tag_d, out_tag_q, out_tag_d;
  logic out_valid_q, out_valid_d, zero_q, zero_d, accept, last;
  assign shamt = op_b[SW-1:0];
  assign in_ready = state_q == IDLE && !flush && (!out_valid_q || out_ready);
  assign accept = in_valid && in_ready;
  assign k = int'(rem_q) > STEP ? KW'(STEP) : KW'(rem_q);
  assign last = int'(rem_q) <= STEP;
  always_comb begin
    case (alu_ctrl)
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = op_a;
      ALU_SLT:  alu_res = DATA_WIDTH'($signed(op_a) < $signed(op_b));
      ALU_SLTU: alu_res = DATA_WIDTH'(op_a < op_b);
      default:  alu_res = op_a + op_b;
    endcase
  end
  pl_shift_step #(.DATA_WIDTH(DATA_WIDTH), .STEP(STEP)) u_step (
    .data_i(data_q), .k_i(k), .mode_i(op_q), .data_o(shifted)
  );
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    rem_d = rem_q;
    op_d = op_q;
    tag_d = tag_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d = result_q;
    zero_d = zero_q;
    out_tag_d = out_tag_q;
    if (accept && (!is_shift(alu_ctrl) || shamt == '0)) begin
      out_valid_d = 1'b1;
      result_d = alu_res;
      zero_d = alu_res == '0;
      out_tag_d = in_tag;
    end else if (accept) begin
      state_d = SHIFT;
      data_d = op_a;
      rem_d = shamt;
      op_d = alu_ctrl_e'(alu_ctrl);
      tag_d = in_tag;
    end
    // Final step writes straight into the output register, which is guaranteed empty.
    if (state_q == SHIFT) begin
      data_d = shifted;
      rem_d = rem_q - SW'(k);
      if (last) begin
        state_d = IDLE;
        out_valid_d = 1'b1;
        result_d = shifted;
        zero_d = shifted == '0;
        out_tag_d = tag_q;
      end
    end
    if (flush) begin
      state_d = IDLE;
      out_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q <= '0;
      rem_q <= '0;
      op_q <= ALU_ADD;
      tag_q <= '0;
      out_valid_q <= 1'b0;
      result_q <= '0;
      zero_q <= 1'b0;
      out_tag_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      rem_q <= rem_d;
      op_q <= op_d;
      tag_q <= tag_d;
      out_valid_q <= out_valid_d;
      result_q <= result_d;
      zero_q <= zero_d;
      out_tag_q <= out_tag_d;
    end
  end
  assign out_valid = out_valid_q;
  assign result = result_q;
  assign zero = zero_q;
  assign out_tag = out_tag_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_pl_alu_exec.sv
// tb_pl_alu_exec: directed scoreboard bench for pl_alu_exec.
module tb_pl_alu_exec;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0] alu_ctrl = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [4:0] in_tag = '0;
  logic in_ready, out_valid, zero, busy;
  logic [31:0] result;
  logic [4:0] out_tag;
  typedef struct packed {logic [31:0] r; logic z; logic [4:0] t;} exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0;
  int n;

  pl_alu_exec dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    int sh;
    logic signed [31:0] sa;
    sh = int'(b[4:0]);
    sa = a;
    case (c)
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return sa >>> sh;
      4'd8: return {31'd0, $signed(a) < $signed(b)};
      4'd9: return {31'd0, a < b};
      default: return a + b;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_out: observed tag %h result %h, expected no output", out_tag, result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result", result, e.r);
        chk("sb_zero", {31'd0, zero}, {31'd0, e.z});
        chk("sb_tag", {27'd0, out_tag}, {27'd0, e.t});
      end
    end
  end

  // Called at posedge+1; returns at accept edge+1 with in_valid dropped.
  task automatic issue(logic [3:0] c, logic [31:0] a, logic [31:0] b, logic [4:0] t, bit push);
    int w;
    logic [31:0] r;
    alu_ctrl = c; op_a = a; op_b = b; in_tag = t; in_valid = 1'b1;
    #1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (w == 50) chk("accept_timeout", {31'd0, in_ready}, 1);
    r = ref_alu(c, a, b);
    if (push) sb.push_back('{r, r == 32'd0, t});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(string tag, int exp_edges);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, n, exp_edges);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", {31'd0, zero}, 0);
    chk("rst_out_tag", {27'd0, out_tag}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", {31'd0, in_ready}, 1);
    @(posedge clk); #1;
    issue(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd1, 1);
    chk("add_valid", {31'd0, out_valid}, 1);
    chk("add_result", result, 0);
    chk("add_zero", {31'd0, zero}, 1);
    issue(4'd8, 32'hFFFF_FFFE, 32'd1, 5'd2, 1);
    chk("slt_result", result, 1);
    issue(4'd9, 32'hFFFF_FFFE, 32'd1, 5'd3, 1);
    chk("sltu_result", result, 0);
    chk("sltu_zero", {31'd0, zero}, 1);
    issue(4'd7, 32'h8000_0000, 32'd31, 5'd4, 1);
    chk("sra_busy", {31'd0, busy}, 1);
    chk("sra_in_ready", {31'd0, in_ready}, 0);
    wait_out("sra_latency", 8);
    chk("sra_result", result, 32'hFFFF_FFFF);
    chk("sra_busy_done", {31'd0, busy}, 0);
    issue(4'd6, 32'h8000_0000, 32'd31, 5'd5, 1);
    wait_out("srl_latency", 8);
    chk("srl_result", result, 32'h0000_0001);
    issue(4'd5, 32'h0000_1234, 32'h0000_0020, 5'd6, 1);
    chk("sll0_fast_valid", {31'd0, out_valid}, 1);
    chk("sll0_result", result, 32'h0000_1234);
    issue(4'd5, 32'h0000_0001, 32'd4, 5'd6, 1);
    wait_out("sll4_latency", 1);
    chk("sll4_result", result, 32'h0000_0010);
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(4'd4, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 5'd7, 1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'd0, out_valid}, 1);
      chk("hold_result", result, 32'hAAAA_AAAA);
      chk("hold_tag", {27'd0, out_tag}, 7);
      chk("hold_in_ready", {31'd0, in_ready}, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    alu_ctrl = 4'd1; op_a = 32'd10; op_b = 32'd3; in_tag = 5'd8; in_valid = 1'b1;
    #1 chk("b2b_in_ready", {31'd0, in_ready}, 1);
    sb.push_back('{32'd7, 1'b0, 5'd8});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_valid", {31'd0, out_valid}, 1);
    chk("b2b_result", result, 7);
    chk("b2b_tag", {27'd0, out_tag}, 8);
    @(posedge clk); #1;
    issue(4'd5, 32'd1, 32'd20, 5'd9, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    alu_ctrl = 4'd0; op_a = 32'd1; op_b = 32'd1; in_tag = 5'd10; in_valid = 1'b1;
    #1 chk("flush_in_ready", {31'd0, in_ready}, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 0);
    chk("flush_busy", {31'd0, busy}, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("flush_quiet_valid", {31'd0, out_valid}, 0);
    chk("flush_quiet_busy", {31'd0, busy}, 0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd31, 5'd11, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst2_out_valid", {31'd0, out_valid}, 0);
    chk("rst2_result", result, 0);
    chk("rst2_zero", {31'd0, zero}, 0);
    chk("rst2_out_tag", {27'd0, out_tag}, 0);
    chk("rst2_busy", {31'd0, busy}, 0);
    issue(4'b1111, 32'd2, 32'd3, 5'd12, 1);
    chk("code15_valid", {31'd0, out_valid}, 1);
    chk("code15_result", result, 5);
    @(posedge clk); #1;
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
